// File: rtl/video_seq_pkg.sv
// Shared state encoding, counter width and parameter defaults for the video
// pipeline bring-up sequencer.
package video_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_PLL     = 3'd0,
        ST_PLL_SETTLE   = 3'd1,
        ST_ADV_INIT     = 3'd2,
        ST_VIDEO_SETTLE = 3'd3,
        ST_RUN          = 3'd4,
        ST_DRAIN        = 3'd5,
        ST_FAULT        = 3'd6
    } seq_state_t;

    localparam int CNT_W            = 20;
    localparam int DEF_PLL_SETTLE   = 4096;
    localparam int DEF_ADV_TIMEOUT  = 1048575;
    localparam int DEF_VIDEO_SETTLE = 1024;
    localparam int DEF_DRAIN        = 2048;
    localparam int DEF_DEBOUNCE     = 256;
    localparam int DEF_MAX_RETRIES  = 3;

    // True on the last cycle of a window of 'limit' cycles.
    function automatic logic cnt_hit(input logic [CNT_W-1:0] cnt, input int unsigned limit);
        return cnt == CNT_W'(limit - 32'd1);
    endfunction

endpackage

// File: rtl/video_pipeline_sequencer_sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output takes a new value
// only after DEBOUNCE consecutive synchronized samples that disagree with it.
module sync_debounce #(
    parameter int DEBOUNCE = 1
) (
    input  logic clock,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          meta_r;
    logic          sync_r;
    logic          db_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then count the run of samples that differ from the accepted value.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            db_r   <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            if (sync_r == db_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(DEBOUNCE - 1)) begin
                db_r  <= sync_r;
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end
    end

    assign dout = db_r;

endmodule

// File: rtl/video_pipeline_sequencer.sv
// Power-up / mode-change sequencer for the PLL -> ADV7513 -> ram2video chain.
// Every output is decoded from the next state and registered alongside it.
module video_pipeline_sequencer
    import video_seq_pkg::*;
#(
    parameter int PLL_SETTLE   = DEF_PLL_SETTLE,
    parameter int ADV_TIMEOUT  = DEF_ADV_TIMEOUT,
    parameter int VIDEO_SETTLE = DEF_VIDEO_SETTLE,
    parameter int DRAIN        = DEF_DRAIN,
    parameter int DEBOUNCE     = DEF_DEBOUNCE,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       line_doubler,
    input  logic       adv_ready,
    output logic       adv_enable,
    output logic       video_enable,
    output logic       line_doubler_out,
    output logic       busy,
    output logic       error,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    logic             rst_meta_r;
    logic             rst_sync_r;
    logic             lock_s;
    logic             mode_s;
    seq_state_t       state_r;
    seq_state_t       nxt_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       retry_r;
    logic [1:0]       retry_nxt_s;
    logic             ldo_r;
    logic             ldo_nxt_s;

    // Reset asserts asynchronously everywhere but releases two edges later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    sync_debounce #(.DEBOUNCE(1)) u_lock_sync (
        .clock (clock),
        .rst_n (rst_sync_r),
        .din   (pll_locked),
        .dout  (lock_s)
    );

    sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_sync (
        .clock (clock),
        .rst_n (rst_sync_r),
        .din   (line_doubler),
        .dout  (mode_s)
    );

    // Next-state logic; lock loss pre-empts every other transition.
    always_comb begin
        nxt_state_s = state_r;
        retry_nxt_s = retry_r;
        ldo_nxt_s   = ldo_r;
        if (!lock_s && (state_r != ST_WAIT_PLL) && (state_r != ST_FAULT)) begin
            nxt_state_s = ST_WAIT_PLL;
        end else begin
            case (state_r)
                ST_WAIT_PLL: begin
                    if (lock_s) nxt_state_s = ST_PLL_SETTLE;
                    else        nxt_state_s = ST_WAIT_PLL;
                end
                ST_PLL_SETTLE: begin
                    if (cnt_hit(cnt_r, PLL_SETTLE)) begin
                        nxt_state_s = ST_ADV_INIT;
                        ldo_nxt_s   = mode_s;
                    end else begin
                        nxt_state_s = ST_PLL_SETTLE;
                    end
                end
                ST_ADV_INIT: begin
                    if (adv_ready) begin
                        nxt_state_s = ST_VIDEO_SETTLE;
                    end else if (cnt_hit(cnt_r, ADV_TIMEOUT)) begin
                        if (retry_r == 2'(MAX_RETRIES)) begin
                            nxt_state_s = ST_FAULT;
                        end else begin
                            retry_nxt_s = retry_r + 2'd1;
                            nxt_state_s = ST_PLL_SETTLE;
                        end
                    end else begin
                        nxt_state_s = ST_ADV_INIT;
                    end
                end
                ST_VIDEO_SETTLE: begin
                    if (cnt_hit(cnt_r, VIDEO_SETTLE)) begin
                        nxt_state_s = ST_RUN;
                        retry_nxt_s = 2'd0;
                    end else begin
                        nxt_state_s = ST_VIDEO_SETTLE;
                    end
                end
                ST_RUN: begin
                    if (mode_s != ldo_r) nxt_state_s = ST_DRAIN;
                    else                 nxt_state_s = ST_RUN;
                end
                ST_DRAIN: begin
                    if (cnt_hit(cnt_r, DRAIN)) begin
                        nxt_state_s = ST_PLL_SETTLE;
                        ldo_nxt_s   = mode_s;
                    end else begin
                        nxt_state_s = ST_DRAIN;
                    end
                end
                ST_FAULT: nxt_state_s = ST_FAULT;
                default:  nxt_state_s = ST_FAULT;
            endcase
        end
    end

    // State, cycle counter and all outputs advance together.
    always_ff @(posedge clock or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            state_r      <= ST_WAIT_PLL;
            cnt_r        <= {CNT_W{1'b0}};
            retry_r      <= 2'd0;
            ldo_r        <= 1'b0;
            adv_enable   <= 1'b0;
            video_enable <= 1'b0;
            busy         <= 1'b1;
            error        <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            if (nxt_state_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            retry_r      <= retry_nxt_s;
            ldo_r        <= ldo_nxt_s;
            adv_enable   <= (nxt_state_s == ST_ADV_INIT) || (nxt_state_s == ST_VIDEO_SETTLE) ||
                            (nxt_state_s == ST_RUN);
            video_enable <= (nxt_state_s == ST_RUN);
            busy         <= (nxt_state_s != ST_RUN);
            error        <= (nxt_state_s == ST_FAULT);
        end
    end

    assign state            = state_r;
    assign retry_count      = retry_r;
    assign line_doubler_out = ldo_r;

endmodule
